// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a valid/ready byte input and a
// one-entry holding register so consecutive frames leave back-to-back.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state,     state_nxt;
  logic [CNT_W-1:0] baud,      baud_nxt;
  logic [2:0]       bit_idx,   bit_idx_nxt;
  logic             stop_idx,  stop_idx_nxt;
  logic [7:0]       shifter,   shifter_nxt;
  logic [7:0]       hold,      hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic             tx_nxt;
  logic             busy_nxt;
  logic             ready_nxt;
  logic             done_nxt;

  logic accept;
  logic bit_end;
  logic final_stop;

  // Handshake and bit-boundary qualifiers shared by the next-state logic
  always_comb begin
    accept     = valid && ready;
    bit_end    = (baud == BAUD_LAST);
    final_stop = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud      <= baud_nxt;
      bit_idx   <= bit_idx_nxt;
      stop_idx  <= stop_idx_nxt;
      shifter   <= shifter_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      tx        <= tx_nxt;
      busy      <= busy_nxt;
      ready     <= ready_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state, datapath and registered-output values
  always_comb begin
    state_nxt     = state;
    baud_nxt      = '0;
    bit_idx_nxt   = bit_idx;
    stop_idx_nxt  = stop_idx;
    shifter_nxt   = shifter;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    tx_nxt        = tx;
    busy_nxt      = busy;
    done_nxt      = 1'b0;

    // A byte arriving mid-frame parks in the holding register; on the final
    // stop edge the STOP branch takes it straight into the shifter instead.
    if (accept && (state != IDLE) && !final_stop) begin
      hold_nxt      = data;
      hold_full_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
        bit_idx_nxt  = '0;
        stop_idx_nxt = 1'b0;
        if (accept) begin
          shifter_nxt = data;
          state_nxt   = START;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end

      START: begin
        baud_nxt = bit_end ? '0 : baud + CNT_W'(1);
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shifter[0];
        end
      end

      DATA: begin
        baud_nxt = bit_end ? '0 : baud + CNT_W'(1);
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt    = STOP;
            stop_idx_nxt = 1'b0;
            tx_nxt       = 1'b1;
          end else begin
            shifter_nxt = shifter >> 1;
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = shifter[1];
          end
        end
      end

      STOP: begin
        baud_nxt = bit_end ? '0 : baud + CNT_W'(1);
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            done_nxt = 1'b1;
            if (hold_full) begin
              shifter_nxt   = hold;
              hold_full_nxt = 1'b0;
              state_nxt     = START;
              tx_nxt        = 1'b0;
            end else if (accept) begin
              shifter_nxt = data;
              state_nxt   = START;
              tx_nxt      = 1'b0;
            end else begin
              state_nxt = IDLE;
              tx_nxt    = 1'b1;
              busy_nxt  = 1'b0;
            end
          end else begin
            stop_idx_nxt = stop_idx + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase

    ready_nxt = !hold_full_nxt;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of uart_transmitter across several
// CLKS_PER_BIT / STOP_BITS settings plus a loopback into a reference decoder.
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance k: 0 -> (4,1), 1 -> (2,1), 2 -> (1,1), 3 -> (2,2)
  logic [3:0] rst_v;
  logic [3:0] valid_v;
  logic [7:0] data_v [4];
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [3:0] ready_v;
  wire  [3:0] done_v;

  int tests = 0;
  int fails = 0;

  uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .valid(valid_v[0]), .data(data_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_transmitter #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .valid(valid_v[1]), .data(data_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .valid(valid_v[2]), .data(data_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_transmitter #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst_v[3]), .valid(valid_v[3]), .data(data_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Reference one-sample-per-bit 8N1 decoder listening to instance 2
  int         rx_cnt = 0;
  int         rx_n   = 0;
  logic [7:0] rx_sh  = 8'h00;
  logic [7:0] rx_got [4];

  always @(negedge clk) begin
    if (rst_v[2]) begin
      rx_cnt <= 0;
    end else if (rx_cnt == 0) begin
      if (tx_v[2] == 1'b0) rx_cnt <= 1;
    end else if (rx_cnt <= 8) begin
      rx_sh  <= {tx_v[2], rx_sh[7:1]};
      rx_cnt <= rx_cnt + 1;
    end else begin
      if (tx_v[2] == 1'b1) begin
        rx_got[rx_n[1:0]] <= rx_sh;
        rx_n <= rx_n + 1;
      end
      rx_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks one whole frame starting at the current negedge (first start-bit
  // cycle). rdy is the ready level expected after the first cycle. (uv,ud) are
  // driven after the first cycle's checks; if late, valid/ld are driven in the
  // final stop cycle. Returns at the negedge of the done cycle.
  task automatic frame(input int idx, input logic [7:0] b, input int cpb, input int sb,
                       input logic rdy, input logic uv, input logic [7:0] ud,
                       input logic late, input logic [7:0] ld);
    int   n;
    int   k;
    logic e;
    n = (9 + sb) * cpb;
    for (int i = 0; i < n; i++) begin
      k = i / cpb;
      if (k == 0)      e = 1'b0;
      else if (k <= 8) e = b[k-1];
      else             e = 1'b1;
      chk($sformatf("u%0d byte %h tx cyc %0d", idx, b, i), 8'(tx_v[idx]), 8'(e));
      chk($sformatf("u%0d byte %h busy cyc %0d", idx, b, i), 8'(busy_v[idx]), 8'h01);
      chk($sformatf("u%0d byte %h ready cyc %0d", idx, b, i), 8'(ready_v[idx]),
          (i == 0) ? 8'h01 : 8'(rdy));
      if (i > 0) chk($sformatf("u%0d byte %h done cyc %0d", idx, b, i), 8'(done_v[idx]), 8'h00);
      if (i == 0) begin
        valid_v[idx] = uv;
        data_v[idx]  = ud;
      end
      if (late && (i == n - 1)) begin
        valid_v[idx] = 1'b1;
        data_v[idx]  = ld;
      end
      @(negedge clk);
    end
    chk($sformatf("u%0d byte %h done pulse", idx, b), 8'(done_v[idx]), 8'h01);
  endtask

  initial begin
    int   w;
    logic bad;

    rst_v   = 4'hF;
    valid_v = 4'h0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

    // Reset values after the first reset edge; valid ignored during reset
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hFF;
    @(negedge clk);
    chk("reset tx",    8'(tx_v),    8'h0F);
    chk("reset busy",  8'(busy_v),  8'h00);
    chk("reset ready", 8'(ready_v), 8'h0F);
    chk("reset done",  8'(done_v),  8'h00);
    step(2);
    chk("reset held tx", 8'(tx_v), 8'h0F);
    valid_v[0] = 1'b0;
    rst_v      = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("idle tx", 8'(tx_v), 8'h0F);
      chk("idle busy", 8'(busy_v), 8'h00);
    end

    // Single byte 0xA5 at 4 clocks per bit
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hA5;
    step(1);
    frame(0, 8'hA5, 4, 1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("u0 after busy", 8'(busy_v[0]), 8'h00);
    chk("u0 after tx", 8'(tx_v[0]), 8'h01);
    step(1);
    chk("u0 done single", 8'(done_v[0]), 8'h00);

    // Two stop bits: 22-cycle frame
    valid_v[3] = 1'b1;
    data_v[3]  = 8'h96;
    step(1);
    frame(3, 8'h96, 2, 2, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("u3 after busy", 8'(busy_v[3]), 8'h00);
    step(1);
    chk("u3 done single", 8'(done_v[3]), 8'h00);
    chk("u3 idle tx", 8'(tx_v[3]), 8'h01);

    // Back-to-back 0x01, 0x02, 0x03 with valid held high
    valid_v[1] = 1'b1;
    data_v[1]  = 8'h01;
    step(1);
    frame(1, 8'h01, 2, 1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00);
    frame(1, 8'h02, 2, 1, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00);
    frame(1, 8'h03, 2, 1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("u1 b2b end busy", 8'(busy_v[1]), 8'h00);
    chk("u1 b2b end tx", 8'(tx_v[1]), 8'h01);
    step(1);
    chk("u1 b2b done", 8'(done_v[1]), 8'h00);

    // Accept exactly on the final stop edge with the holding register empty
    valid_v[1] = 1'b1;
    data_v[1]  = 8'h11;
    step(1);
    frame(1, 8'h11, 2, 1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A);
    frame(1, 8'h5A, 2, 1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("u1 late end busy", 8'(busy_v[1]), 8'h00);
    step(1);
    chk("u1 late done", 8'(done_v[1]), 8'h00);

    // Reset during DATA bit 3 with the holding register full
    valid_v[1] = 1'b1;
    data_v[1]  = 8'h77;
    step(1);
    data_v[1] = 8'h88;
    step(1);
    valid_v[1] = 1'b0;
    chk("u1 hold full ready", 8'(ready_v[1]), 8'h00);
    step(7);
    chk("u1 bit3 tx", 8'(tx_v[1]), 8'h00);
    chk("u1 bit3 busy", 8'(busy_v[1]), 8'h01);
    rst_v[1] = 1'b1;
    step(1);
    chk("u1 midrst tx", 8'(tx_v[1]), 8'h01);
    chk("u1 midrst busy", 8'(busy_v[1]), 8'h00);
    chk("u1 midrst ready", 8'(ready_v[1]), 8'h01);
    chk("u1 midrst done", 8'(done_v[1]), 8'h00);
    step(2);
    rst_v[1] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (tx_v[1] !== 1'b1 || done_v[1] !== 1'b0 || busy_v[1] !== 1'b0) bad = 1'b1;
    end
    chk("u1 quiet after reset", 8'(bad), 8'h00);

    // Loopback at 1 clock per bit: 0x3C then 0xC3 back-to-back
    valid_v[2] = 1'b1;
    data_v[2]  = 8'h3C;
    step(1);
    data_v[2] = 8'hC3;
    step(1);
    valid_v[2] = 1'b0;
    w = 0;
    while (rx_n < 2 && w < 40) begin
      step(1);
      w++;
    end
    step(15);
    chk("loopback count", 8'(rx_n), 8'h02);
    chk("loopback byte0", rx_got[0], 8'h3C);
    chk("loopback byte1", rx_got[1], 8'hC3);
    chk("loopback idle tx", 8'(tx_v[2]), 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
